// File: rtl/frame_parser_pp.sv
// -----------------------------------------------------------------------------
// frame_parser_pp
// Hunts a 16-bit word stream for framed payloads of the form
//    HEADER(2 words) CHANNEL(1) payload(1..MAX_WORDS) CRC16(1) TRAILER(2)
// checks the channel word and the CRC16-CCITT over the payload, stores good
// frames in a two-entry ping-pong buffer and replays them word by word on a
// valid/ready output stream (optionally Gray-coded).
//
// Ports
//    clk_in     single clock for the whole block
//    rst_n      synchronous reset, active low
//    data_in    stream word, big-endian
//    in_vld     data_in qualifier; cycles with in_vld=0 leave the parser untouched
//    out_valid  output word valid
//    out_ready  downstream accepts the word when out_valid & out_ready
//    out_data   payload word (Gray-coded when GRAY_EN=1)
//    out_last   final word of the frame
//    out_ch     one-hot channel, stable for the whole frame
//    out_len    payload word count, stable for the whole frame
//    frame_ok   pulse: frame passed all checks and was stored
//    crc_err    pulse: CRC mismatch, frame discarded
//    ch_err     pulse: channel word not one-hot within [N_CH-1:0]
//    len_err    pulse: zero payload words or more than MAX_WORDS
//    drop_err   pulse: good frame lost because both entries are occupied
// -----------------------------------------------------------------------------
module frame_parser_pp #(
   parameter int          N_CH      = 8,
   parameter int          MAX_WORDS = 8,
   parameter logic [31:0] HEADER    = 32'hE0E0E0E0,
   parameter logic [31:0] TRAILER   = 32'h0E0E0E0E,
   parameter logic [15:0] CRC_INIT  = 16'h0000,
   parameter bit          GRAY_EN   = 1'b1
) (
   input  logic                               clk_in,
   input  logic                               rst_n,
   input  logic [15:0]                        data_in,
   input  logic                               in_vld,
   output logic                               out_valid,
   input  logic                               out_ready,
   output logic [15:0]                        out_data,
   output logic                               out_last,
   output logic [N_CH-1:0]                    out_ch,
   output logic [$clog2(MAX_WORDS+1)-1:0]     out_len,
   output logic                               frame_ok,
   output logic                               crc_err,
   output logic                               ch_err,
   output logic                               len_err,
   output logic                               drop_err
);

   localparam int LW = $clog2(MAX_WORDS + 1);
   localparam int IW = (MAX_WORDS > 1) ? $clog2(MAX_WORDS) : 1;
   localparam int CW = $clog2(MAX_WORDS + 4);

   // Body word count at which a frame without trailer is abandoned.
   localparam logic [CW-1:0] CNT_END = CW'(MAX_WORDS + 3);

   typedef enum logic [1:0] {HUNT_H, HUNT_L, CHAN, BODY} state_t;

   // CRC16-CCITT, polynomial 0x1021, whole word folded in MSB first.
   function automatic logic [15:0] crc16_word(input logic [15:0] crc, input logic [15:0] w);
      logic [15:0] c;
      logic        fb;
      c = crc;
      for (int i = 15; i >= 0; i--) begin
         fb = c[15] ^ w[i];
         c  = {c[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
      end
      return c;
   endfunction

   function automatic logic [15:0] out_code(input logic [15:0] w);
      return GRAY_EN ? (w ^ (w >> 1)) : w;
   endfunction

   // Parser state
   state_t        state;
   logic [CW-1:0] cnt;          // body words received before the current one
   logic [15:0]   lag0;         // newest body word
   logic [15:0]   lag1;
   logic [15:0]   lag2;         // oldest word still held back
   logic [15:0]   crc;
   logic [15:0]   ch_word;
   logic          wr_lost;      // a payload word could not be stored this frame
   logic          wr_sel;       // entry being filled

   // Frame storage; contents are only meaningful while the entry is committed
   logic [15:0]   mem     [2][MAX_WORDS];
   logic [N_CH-1:0] ent_ch  [2];
   logic [LW-1:0] ent_len [2];

   // Drain state
   logic [1:0]    pend;         // committed, words still to be loaded into the output stage
   logic [1:0]    occ;          // committed, out_last not yet accepted
   logic          ld_sel;       // entry the output stage loads from
   logic          fr_sel;       // entry freed by the next out_last acceptance
   logic [IW-1:0] ld_idx;

   // Combinational decode
   logic          body_s;
   logic          trl_hit_s;
   logic          shift_s;
   logic          end_s;
   logic [15:0]   crc_next_s;
   logic [15:0]   crc_fin_s;
   logic          ch_ok_s;
   logic          len_bad_s;
   logic          full_s;
   logic          wr_en_s;
   logic [IW-1:0] wr_idx_s;
   logic [LW-1:0] len_s;
   logic          v_ok_s;
   logic          v_crc_s;
   logic          v_ch_s;
   logic          v_len_s;
   logic          v_drop_s;
   logic          adv_s;
   logic [15:0]   word_s;
   logic          last_word_s;
   logic          accept_last_s;
   logic [1:0]    pend_n_s;
   logic [1:0]    occ_n_s;

   // Frame-end detection, CRC folding and verdict with its priority order
   always_comb begin
      body_s     = in_vld && (state == BODY);
      // Trailer low word arriving with trailer high word just ahead of it.
      trl_hit_s  = body_s && (cnt >= CW'(2)) && (data_in == TRAILER[15:0])
                   && (lag0 == TRAILER[31:16]);
      // Word leaving the lag line is a payload word (guarded against overrun).
      shift_s    = body_s && (cnt >= CW'(3)) && (cnt < CNT_END);
      end_s      = trl_hit_s || (body_s && (cnt == CNT_END));
      crc_next_s = crc16_word(crc, lag2);
      crc_fin_s  = shift_s ? crc_next_s : crc;
      ch_ok_s    = (ch_word != 16'h0000) && ((ch_word & (ch_word - 16'h0001)) == 16'h0000)
                   && ((ch_word >> N_CH) == 16'h0000);
      len_bad_s  = !trl_hit_s || (cnt < CW'(3)) || (cnt == CNT_END);
      full_s     = occ[wr_sel] || wr_lost;
      wr_en_s    = shift_s && !occ[wr_sel];
      wr_idx_s   = IW'(cnt - CW'(3));
      len_s      = LW'(cnt - CW'(2));

      v_ok_s   = 1'b0;
      v_crc_s  = 1'b0;
      v_ch_s   = 1'b0;
      v_len_s  = 1'b0;
      v_drop_s = 1'b0;
      if (!end_s) begin
         v_ok_s = 1'b0;
      end else if (len_bad_s) begin
         v_len_s = 1'b1;
      end else if (!ch_ok_s) begin
         v_ch_s = 1'b1;
      end else if (crc_fin_s != lag1) begin
         v_crc_s = 1'b1;
      end else if (full_s) begin
         v_drop_s = 1'b1;
      end else begin
         v_ok_s = 1'b1;
      end
   end

   // Output-side decode and next occupancy; commit and free never hit the same entry
   always_comb begin
      adv_s         = !out_valid || out_ready;
      word_s        = mem[ld_sel][ld_idx];
      last_word_s   = ((LW'(ld_idx) + LW'(1)) == ent_len[ld_sel]);
      accept_last_s = out_valid && out_ready && out_last;
      pend_n_s      = pend;
      occ_n_s       = occ;
      if (accept_last_s) begin
         occ_n_s[fr_sel] = 1'b0;
      end else begin
         occ_n_s = occ_n_s;
      end
      if (adv_s && pend[ld_sel] && last_word_s) begin
         pend_n_s[ld_sel] = 1'b0;
      end else begin
         pend_n_s = pend_n_s;
      end
      if (v_ok_s) begin
         pend_n_s[wr_sel] = 1'b1;
         occ_n_s[wr_sel]  = 1'b1;
      end else begin
         occ_n_s = occ_n_s;
      end
   end

   // Parser FSM: header hunt, channel latch, body lag line, verdict pulses
   always_ff @(posedge clk_in) begin
      if (!rst_n) begin
         state    <= HUNT_H;
         cnt      <= '0;
         lag0     <= 16'h0000;
         lag1     <= 16'h0000;
         lag2     <= 16'h0000;
         crc      <= CRC_INIT;
         ch_word  <= 16'h0000;
         wr_lost  <= 1'b0;
         wr_sel   <= 1'b0;
         frame_ok <= 1'b0;
         crc_err  <= 1'b0;
         ch_err   <= 1'b0;
         len_err  <= 1'b0;
         drop_err <= 1'b0;
      end else begin
         frame_ok <= v_ok_s;
         crc_err  <= v_crc_s;
         ch_err   <= v_ch_s;
         len_err  <= v_len_s;
         drop_err <= v_drop_s;
         if (v_ok_s) begin
            wr_sel <= ~wr_sel;
         end
         if (in_vld) begin
            case (state)
               HUNT_H: begin
                  if (data_in == HEADER[31:16]) state <= HUNT_L;
                  else                          state <= HUNT_H;
               end
               HUNT_L: begin
                  // Low-word match wins, so a header with equal halves still locks.
                  if (data_in == HEADER[15:0])       state <= CHAN;
                  else if (data_in == HEADER[31:16]) state <= HUNT_L;
                  else                               state <= HUNT_H;
               end
               CHAN: begin
                  ch_word <= data_in;
                  cnt     <= '0;
                  crc     <= CRC_INIT;
                  wr_lost <= 1'b0;
                  state   <= BODY;
               end
               BODY: begin
                  if (end_s) begin
                     state <= HUNT_H;
                  end else begin
                     lag0 <= data_in;
                     lag1 <= lag0;
                     lag2 <= lag1;
                     cnt  <= cnt + CW'(1);
                     if (shift_s) begin
                        crc <= crc_next_s;
                        if (occ[wr_sel]) wr_lost <= 1'b1;
                     end
                  end
               end
               default: state <= HUNT_H;
            endcase
         end
      end
   end

   // Payload and per-entry metadata storage
   always_ff @(posedge clk_in) begin
      if (wr_en_s) begin
         mem[wr_sel][wr_idx_s] <= lag2;
      end
      if (v_ok_s) begin
         ent_ch[wr_sel]  <= ch_word[N_CH-1:0];
         ent_len[wr_sel] <= len_s;
      end
   end

   // Output stage: loads the next stored word whenever the current one is gone
   always_ff @(posedge clk_in) begin
      if (!rst_n) begin
         pend      <= 2'b00;
         occ       <= 2'b00;
         ld_sel    <= 1'b0;
         fr_sel    <= 1'b0;
         ld_idx    <= '0;
         out_valid <= 1'b0;
         out_data  <= 16'h0000;
         out_last  <= 1'b0;
         out_ch    <= '0;
         out_len   <= '0;
      end else begin
         pend <= pend_n_s;
         occ  <= occ_n_s;
         if (accept_last_s) begin
            fr_sel <= ~fr_sel;
         end
         if (adv_s) begin
            if (pend[ld_sel]) begin
               out_valid <= 1'b1;
               out_data  <= out_code(word_s);
               out_last  <= last_word_s;
               out_ch    <= ent_ch[ld_sel];
               out_len   <= ent_len[ld_sel];
               if (last_word_s) begin
                  ld_idx <= '0;
                  ld_sel <= ~ld_sel;
               end else begin
                  ld_idx <= ld_idx + IW'(1);
               end
            end else begin
               out_valid <= 1'b0;
               out_last  <= 1'b0;
            end
         end
      end
   end

endmodule
